// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle vertical physics engine.
// Also holds the unpacking helper for the packed per-platform coordinate buses.
package doodle_pkg;

  typedef enum logic [1:0] {
    FALL  = 2'd0,
    RIDE  = 2'd1,
    BOOST = 2'd2
  } state_t;

  localparam int COORD_W     = 10;
  localparam int DOODLE_SIZE = 20;
  localparam int PLAT_WIDTH  = 75;
  localparam int MAX_PLAT    = 16;

  // Callers zero-extend their NUM_PLAT*COORD_W bus into the MAX_PLAT-wide container.
  function automatic logic [COORD_W-1:0] plat_at(input logic [MAX_PLAT*COORD_W-1:0] vec,
                                                 input int idx);
    return vec[idx*COORD_W +: COORD_W];
  endfunction

endpackage

// File: rtl/doodle_land_detect.sv
// Combinational landing search: per-platform horizontal overlap plus crossing test.
// The crossing test spans the whole d_y..d_y+vel interval, so no platform can be skipped.
module doodle_land_detect
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT = 7,
  parameter int W        = COORD_W,
  parameter int SIZE     = DOODLE_SIZE,
  parameter int PLAT_W   = PLAT_WIDTH,
  parameter int IDX_W    = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
  input  logic [W-1:0]          d_x,
  input  logic [W-1:0]          d_y,
  input  logic [W-1:0]          vel,
  input  logic [NUM_PLAT*W-1:0] plat_vpos,
  input  logic [NUM_PLAT*W-1:0] plat_hpos,
  output logic                  hit,
  output logic [IDX_W-1:0]      hit_idx,
  output logic [W-1:0]          hit_vpos,
  output logic [NUM_PLAT-1:0]   overlap
);

  localparam logic [W:0] SIZE_X = (W+1)'(SIZE);
  localparam logic [W:0] PLAT_X = (W+1)'(PLAT_W);

  logic [MAX_PLAT*COORD_W-1:0] vpos_ext;
  logic [MAX_PLAT*COORD_W-1:0] hpos_ext;
  logic [W:0]                  cand;
  logic [W-1:0]                vp;
  logic [W-1:0]                hp;
  logic [W-1:0]                plat_top;
  logic                        crosses;

  always_comb begin
    vpos_ext                   = '0;
    hpos_ext                   = '0;
    vpos_ext[NUM_PLAT*W-1:0]   = plat_vpos;
    hpos_ext[NUM_PLAT*W-1:0]   = plat_hpos;
    cand                       = {1'b0, d_y} + {1'b0, vel};
    hit                        = 1'b0;
    hit_idx                    = '0;
    hit_vpos                   = '0;
    overlap                    = '0;
    vp                         = '0;
    hp                         = '0;
    plat_top                   = '0;
    crosses                    = 1'b0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      vp         = W'(plat_at(vpos_ext, i));
      hp         = W'(plat_at(hpos_ext, i));
      // A zero vpos marks an empty slot; it never overlaps, so riding it also ends.
      overlap[i] = (({1'b0, d_x} + SIZE_X) > {1'b0, hp}) &&
                   ({1'b0, d_x} < ({1'b0, hp} + PLAT_X)) &&
                   (vp != '0);
      plat_top   = vp - 1'b1;
      crosses    = overlap[i] && (d_y <= plat_top) && (cand >= {1'b0, plat_top});
      // Strict less-than keeps the lowest index on a vpos tie.
      if (crosses && (!hit || (vp < hit_vpos))) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_vpos = vp;
      end
    end
  end

endmodule

// File: rtl/doodle_y_engine.sv
// Vertical physics for the doodle sprite: gravity with terminal velocity, landing,
// riding moving platforms, timed boost off power platforms, and a sticky fall-out flag.
module doodle_y_engine
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT    = 7,
  parameter int W           = COORD_W,
  parameter int SIZE        = DOODLE_SIZE,
  parameter int PLAT_W      = PLAT_WIDTH,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 6,
  parameter int BOOST_V     = 4,
  parameter int BOOST_TICKS = 40,
  parameter int START_Y     = 300,
  parameter int SCREEN_H    = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  terminated,
  input  logic [NUM_PLAT*W-1:0] plat_vpos,
  input  logic [NUM_PLAT*W-1:0] plat_hpos,
  input  logic [NUM_PLAT-1:0]   is_power,
  input  logic [W-1:0]          d_x,
  output logic [W-1:0]          d_y,
  output logic                  power_signal,
  output logic                  on_platform,
  output logic                  fell_out
);

  localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam int CNT_W = $clog2(BOOST_TICKS + 1);

  localparam logic [W-1:0]     START_Y_W  = W'(START_Y);
  localparam logic [W:0]       GRAVITY_X  = (W+1)'(GRAVITY);
  localparam logic [W:0]       MAX_FALL_X = (W+1)'(MAX_FALL);
  localparam logic [W-1:0]     BOOST_V_W  = W'(BOOST_V);
  localparam logic [W:0]       SCREEN_H_X = (W+1)'(SCREEN_H);
  localparam logic [CNT_W-1:0] BOOST_INIT = CNT_W'(BOOST_TICKS);
  localparam logic [CNT_W-1:0] BOOST_LAST = CNT_W'(1);

  state_t           state;
  logic [W-1:0]     vel;
  logic [CNT_W-1:0] boost_cnt;
  logic [IDX_W-1:0] ride_idx;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic [W-1:0]          hit_vpos;
  logic [NUM_PLAT-1:0]   overlap;

  logic                        adv;
  logic [W:0]                  cand;
  logic [W:0]                  vel_inc;
  logic [W-1:0]                vel_next;
  logic [W-1:0]                boost_y;
  logic [MAX_PLAT*COORD_W-1:0] vpos_ext;
  logic [W-1:0]                ride_vpos;

  doodle_land_detect #(
    .NUM_PLAT (NUM_PLAT),
    .W        (W),
    .SIZE     (SIZE),
    .PLAT_W   (PLAT_W),
    .IDX_W    (IDX_W)
  ) u_land (
    .d_x       (d_x),
    .d_y       (d_y),
    .vel       (vel),
    .plat_vpos (plat_vpos),
    .plat_hpos (plat_hpos),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_vpos  (hit_vpos),
    .overlap   (overlap)
  );

  always_comb begin
    adv                      = tick && !terminated && !fell_out;
    cand                     = {1'b0, d_y} + {1'b0, vel};
    vel_inc                  = {1'b0, vel} + GRAVITY_X;
    vel_next                 = (vel_inc > MAX_FALL_X) ? MAX_FALL_X[W-1:0] : vel_inc[W-1:0];
    boost_y                  = (d_y >= BOOST_V_W) ? (d_y - BOOST_V_W) : '0;
    vpos_ext                 = '0;
    vpos_ext[NUM_PLAT*W-1:0] = plat_vpos;
    ride_vpos                = W'(plat_at(vpos_ext, int'(ride_idx)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FALL;
      d_y          <= START_Y_W;
      vel          <= '0;
      boost_cnt    <= '0;
      ride_idx     <= '0;
      power_signal <= 1'b0;
      on_platform  <= 1'b0;
      fell_out     <= 1'b0;
    end else begin
      power_signal <= 1'b0;
      if (adv) begin
        case (state)
          FALL: begin
            if (hit) begin
              d_y      <= hit_vpos - 1'b1;
              vel      <= '0;
              ride_idx <= hit_idx;
              if (is_power[hit_idx]) begin
                state        <= BOOST;
                boost_cnt    <= BOOST_INIT;
                power_signal <= 1'b1;
                on_platform  <= 1'b0;
              end else begin
                state       <= RIDE;
                on_platform <= 1'b1;
              end
            end else begin
              d_y <= cand[W-1:0];
              vel <= vel_next;
              // A landing always snaps d_y above the floor, so only free fall can exit.
              if (cand >= SCREEN_H_X) fell_out <= 1'b1;
            end
          end
          RIDE: begin
            if (overlap[ride_idx]) begin
              d_y <= ride_vpos - 1'b1;
            end else begin
              state       <= FALL;
              vel         <= '0;
              on_platform <= 1'b0;
            end
          end
          BOOST: begin
            d_y <= boost_y;
            if (boost_cnt <= BOOST_LAST) begin
              state     <= FALL;
              vel       <= '0;
              boost_cnt <= '0;
            end else begin
              boost_cnt <= boost_cnt - 1'b1;
            end
          end
          default: begin
            state       <= FALL;
            vel         <= '0;
            on_platform <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_doodle_y_engine.sv
// Directed bench for doodle_y_engine: free fall, landing, riding, boost, priority,
// freeze and fall-out, with hand-computed expected positions.
module tb_doodle_y_engine;

  localparam int NP = 7;
  localparam int W  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick;
  logic            terminated;
  logic [NP*W-1:0] plat_vpos;
  logic [NP*W-1:0] plat_hpos;
  logic [NP-1:0]   is_power;
  logic [W-1:0]    d_x;
  logic [W-1:0]    d_y;
  logic            power_signal;
  logic            on_platform;
  logic            fell_out;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fall [8] = '{300, 301, 303, 306, 310, 315, 321, 327};

  doodle_y_engine dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .terminated   (terminated),
    .plat_vpos    (plat_vpos),
    .plat_hpos    (plat_hpos),
    .is_power     (is_power),
    .d_x          (d_x),
    .d_y          (d_y),
    .power_signal (power_signal),
    .on_platform  (on_platform),
    .fell_out     (fell_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_plat(input int i, input int vpos, input int hpos);
    plat_vpos[i*W +: W] = W'(vpos);
    plat_hpos[i*W +: W] = W'(hpos);
  endtask

  // One tick pulse; returns at the negedge right after the tick edge.
  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; terminated = 1'b0;
    plat_vpos = '0; plat_hpos = '0; is_power = '0; d_x = 10'd100;
    repeat (3) @(negedge clk);
    check("rst_dy", d_y, 300);
    check("rst_on", on_platform, 0);
    check("rst_fell", fell_out, 0);
    check("rst_pwr", power_signal, 0);
    rst = 1'b1;

    // Free fall with terminal velocity
    for (int k = 0; k < 8; k++) begin
      do_tick();
      check($sformatf("fall_%0d", k), d_y, exp_fall[k]);
    end
    repeat (2) @(negedge clk);
    check("hold_no_tick", d_y, 327);

    // Landing at full speed on a narrow crossing window
    set_plat(0, 330, 80);
    do_tick();
    check("tunnel_dy", d_y, 329);
    check("tunnel_on", on_platform, 1);
    check("tunnel_pwr", power_signal, 0);

    // Ride a rising platform
    for (int k = 1; k <= 10; k++) begin
      set_plat(0, 330 - k, 80);
      do_tick();
      check($sformatf("ride_%0d", k), d_y, 329 - k);
    end

    // Walk off the right edge
    d_x = 10'd155;
    do_tick();
    check("walk_on", on_platform, 0);
    check("walk_dy0", d_y, 319);
    do_tick();
    check("walk_dy1", d_y, 319);
    do_tick();
    check("walk_dy2", d_y, 320);

    // Power landing and boost, frozen halfway by terminated
    set_plat(0, 0, 80);
    d_x = 10'd100;
    set_plat(2, 323, 90);
    is_power[2] = 1'b1;
    do_tick();
    check("pwr_dy", d_y, 322);
    check("pwr_pulse", power_signal, 1);
    check("pwr_on", on_platform, 0);
    @(negedge clk);
    check("pwr_pulse_end", power_signal, 0);
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      check($sformatf("boost_%0d", k), d_y, 322 - 4 * k);
    end
    terminated = 1'b1;
    repeat (3) do_tick();
    check("freeze_dy", d_y, 242);
    terminated = 1'b0;
    for (int k = 21; k <= 40; k++) begin
      do_tick();
      check($sformatf("boost_%0d", k), d_y, 322 - 4 * k);
    end
    do_tick();
    check("boost_exit_dy", d_y, 162);

    // Plain landing after boost: no power pulse
    set_plat(2, 0, 90);
    set_plat(3, 165, 90);
    do_tick();
    check("plain_fall", d_y, 163);
    do_tick();
    check("plain_dy", d_y, 164);
    check("plain_pwr", power_signal, 0);
    check("plain_on", on_platform, 1);

    // Equal-vpos tie: lowest index wins
    d_x = 10'd200;
    do_tick();
    check("tie_leave_on", on_platform, 0);
    set_plat(3, 0, 90);
    repeat (4) do_tick();
    check("tie_pre_dy", d_y, 170);
    set_plat(1, 173, 190);
    set_plat(5, 173, 190);
    do_tick();
    check("tie_land_dy", d_y, 172);
    check("tie_land_on", on_platform, 1);
    set_plat(5, 180, 190);
    set_plat(1, 176, 190);
    do_tick();
    check("tie_ride_idx1", d_y, 175);

    // Smaller vpos beats lower index
    d_x = 10'd300;
    do_tick();
    set_plat(1, 0, 0);
    set_plat(5, 0, 0);
    repeat (3) do_tick();
    check("prio_pre_dy", d_y, 178);
    set_plat(0, 182, 290);
    set_plat(6, 180, 290);
    do_tick();
    check("prio_land_dy", d_y, 179);
    set_plat(6, 185, 290);
    set_plat(0, 190, 290);
    do_tick();
    check("prio_ride_idx6", d_y, 184);

    // Fall out of the screen
    d_x = 10'd500;
    do_tick();
    check("out_leave_on", on_platform, 0);
    set_plat(0, 0, 0);
    set_plat(6, 0, 0);
    repeat (52) do_tick();
    check("out_pre_dy", d_y, 475);
    check("out_pre_flag", fell_out, 0);
    do_tick();
    check("out_dy", d_y, 481);
    check("out_flag", fell_out, 1);
    repeat (2) do_tick();
    check("out_frozen_dy", d_y, 481);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_dy", d_y, 300);
    check("arst_fell", fell_out, 0);
    check("arst_on", on_platform, 0);
    @(negedge clk) rst = 1'b1;
    do_tick();
    check("post_rst_dy", d_y, 300);
    do_tick();
    check("post_rst_dy2", d_y, 301);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/doodle_y_engine.md
Name: doodle_y_engine

Overview:
- Vertical physics engine for the doodle sprite; replaces the fixed 7-platform, constant-gravity position block.
- Generalised to NUM_PLAT platforms, accelerating fall with terminal velocity, and crossing-based landing that cannot tunnel.
- Adds a timed upward boost on power platforms and a fall-out flag.
- Sits between the platform generator (positions, power mask) and the renderer/game FSM (d_y, power_signal, fell_out).

Parameters:
- NUM_PLAT, 7, number of platforms.
- W, 10, coordinate width in bits.
- SIZE, 20, doodle width in px.
- PLAT_W, 75, platform width in px.
- GRAVITY, 1, fall-speed increment per tick.
- MAX_FALL, 6, terminal fall speed in px/tick.
- BOOST_V, 4, upward px/tick during boost.
- BOOST_TICKS, 40, boost duration in ticks.
- START_Y, 300, reset y position.
- SCREEN_H, 480, y at or beyond which the doodle has fallen out.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- tick  in  1  physics-step enable, one clk wide.
- terminated  in  1  game over; freezes all state.
- plat_vpos  in  NUM_PLAT*W  packed platform top y; platform i occupies bits [i*W +: W].
- plat_hpos  in  NUM_PLAT*W  packed platform left x.
- is_power  in  NUM_PLAT  power-platform mask.
- d_x  in  W  doodle left x.
- d_y  out  W  doodle bottom y.
- power_signal  out  1  one-clk pulse on landing on a power platform.
- on_platform  out  1  high while in RIDE.
- fell_out  out  1  sticky; doodle left the bottom of the screen.

Behaviour:
- Reset values: d_y=START_Y, state=FALL, vel=0, boost_cnt=0, ride_idx=0, power_signal=0, on_platform=0, fell_out=0.
- State only advances on clk cycles with tick=1 && !terminated && !fell_out. On all other cycles state holds and power_signal=0.
- Overlap for platform i: d_x+SIZE > hpos_i && d_x < hpos_i+PLAT_W. Compute in W+1 bits.
- Platforms with vpos_i==0 are ignored.
- FALL:
  - cand = d_y + vel, computed in W+1 bits.
  - Platform i is hit if it overlaps, d_y <= vpos_i-1, and cand >= vpos_i-1.
  - Among hits, pick the smallest vpos; on a tie, the lowest index.
  - On hit: d_y <= vpos_i-1, vel <= 0, ride_idx <= i.
    - If is_power[i]: go to BOOST, boost_cnt <= BOOST_TICKS, power_signal=1 for that one cycle.
    - Otherwise: go to RIDE.
  - No hit: d_y <= cand, vel <= min(vel+GRAVITY, MAX_FALL).
  - If cand >= SCREEN_H: fell_out <= 1 (sticky until reset).
- RIDE:
  - If ride_idx still overlaps: d_y <= vpos_ride-1. The doodle tracks the moving platform exactly, with no drift.
  - If overlap is lost: go to FALL, vel <= 0, d_y unchanged.
  - No power_signal in RIDE. Only a fresh landing from FALL fires it.
- BOOST:
  - d_y <= max(d_y-BOOST_V, 0), boost_cnt decrements.
  - Landing is not checked during BOOST.
  - When boost_cnt reaches 1 on a tick: go to FALL with vel=0.
- Simultaneous events:
  - terminated rising mid-BOOST freezes boost_cnt.
  - rst overrides everything, any state, immediately (async).
  - A power landing and fell_out cannot coincide, because landing snaps d_y below SCREEN_H.
- Latency: every output is registered. d_y updates on the clk edge where tick=1.

Decomposition:
- Package doodle_pkg holds:
  - the state enum {FALL, RIDE, BOOST};
  - shared constants SIZE, PLAT_W, coordinate width;
  - a function that unpacks platform i from the packed vectors.
- Sub-module doodle_land_detect (combinational), parametrised by NUM_PLAT and W.
  - Inputs: d_x, d_y, vel, packed positions.
  - Outputs: hit, hit_idx, hit_vpos, and a per-platform overlap vector.
  - The engine FSM instantiates it once.

Test Plan:
1. Reset: rst=0 → d_y=300, FALL, all flags 0. Release rst, no platforms, tick every 4 clk → d_y sequence 300,300,301,303,306,310,315,321,327 (vel capped at 6).
2. Tunnelling: vel=6, d_y=297, platform at vpos 300 overlapping → next tick d_y=299, on_platform=1. A test with 3-px windows would have missed it.
3. Ride and walk-off: platform rising 1px/tick, d_y tracks vpos-1 for each of 10 ticks. Then move d_x so d_x >= hpos+75 → FALL, d_y holds for one tick, then increases.
4. Power: land on platform 2 with is_power[2]=1 → power_signal high exactly 1 clk. d_y decreases by 4 for 40 ticks, then FALL. A following non-power landing gives power_signal=0.
5. Tie/priority: two overlapping platforms at vpos 200 (idx 5) and 200 (idx 1) crossed in one tick → ride_idx=1. With vpos 200 vs 202 → the 200 platform wins.
6. Freeze/fall-out: terminated=1 mid-BOOST → d_y and boost_cnt constant. Free fall past 480 → fell_out=1, d_y frozen. rst asserted → all reset values restored.
